aes_key_expansion: RTL and testbench
====================================

Name: aes_key_expansion

Overview:
- Sequential AES-128 key schedule generator that sits directly upstream of the AddRoundKey stage.
- Latches a 128-bit cipher key and produces round keys 0..10 one at a time, each on a valid/ready handshake.
- The cipher datapath consumes each round key as the `key` operand of AddRoundKey.
- One round key is computed per accepted handshake, so no 1408-bit schedule storage is needed in the base build.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128, other values unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle request to begin a schedule; sampled only in IDLE.
- key_in  input  128  cipher key, sampled on the start cycle; bits [127:96] = w0.
- ready  input  1  consumer accepts the current round_key when ready && key_valid.
- round_key  output  128  current round key; bits [127:96] = first word.
- round_num  output  4  index of round_key, 0..10.
- key_valid  output  1  round_key/round_num are valid.
- busy  output  1  high from the cycle after start acceptance until round 10 is accepted.
- done  output  1  one-cycle pulse after round 10 is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - round_key=0, round_num=0, key_valid=0, busy=0, done=0.
  - Rcon register = 8'h01; state = IDLE.
  - Reset mid-schedule aborts immediately; no partial output survives.
- States: IDLE, GEN.
- IDLE:
  - done is a registered pulse and clears after one cycle in IDLE.
  - On start=1 at a clock edge: after that edge round_key=key_in, round_num=0, key_valid=1, busy=1, Rcon=01; go to GEN.
  - start is honoured in the same cycle done is high.
- GEN, on an edge with key_valid && ready && round_num<10:
  - Compute the next round key from the current one and latch it; round_num+1; key_valid stays 1.
  - Rcon advances 01,02,04,08,10,20,40,80,1b,36 (xtime; 80 -> 1b).
- GEN, on an edge with key_valid && ready && round_num==10:
  - key_valid=0, busy=0, done=1; go to IDLE.
  - round_key and round_num hold their last values.
- GEN with ready=0: all outputs hold (standard stall; no combinational path from ready to outputs).
- Round key function, with w0..w3 the current words:
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}
  - w4 = w0^t, w5 = w4^w1, w6 = w5^w2, w7 = w6^w3.
- RotWord: {b1,b2,b3,b0}.
- SubWord: the FIPS-197 S-box applied to each byte; 4 combinational S-box lookups, implemented internally.
- Latency:
  - Start to round 0 valid: 1 edge.
  - Each accept to the next key: 1 edge.
  - With ready held high: 11 consecutive valid cycles, then done on the 12th cycle.
- start while busy: ignored, with no effect on key or state.
- key_in changes after the start edge: no effect.

Optional Feature:
- Macro: AES_KEY_EXP_LAST_KEY_EN.
- Defined:
  - Adds output last_key [127:0], reset 0.
  - Loaded with the round-10 key on the edge where round 10 first becomes valid.
  - Holds until the next round-10 key or reset; used as the starting key for the decryption schedule.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- FIPS-197 key, ready=1:
  - Pulse start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - Round 0 = 2b7e1516..., round 1 = a0fafe1788542cb123a339392a6c7605, round 2 = f2c295f27a96b9435935807a7359f67f.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses exactly once, 11 cycles after the first key_valid.
- Backpressure:
  - Hold ready=0 for 5 cycles while round 3 is valid (round_key=3d80477d4716fe3e1e237e446d7a883b).
  - Outputs stay stable; on release, round 4 follows on the next edge.
- Start while busy:
  - Pulse start with key_in=0 at round 5.
  - Sequence continues unchanged to the FIPS round 10 key.
- Async reset mid-schedule:
  - Drop rst at round 6, mid-cycle.
  - Outputs go to 0 immediately without a clock edge.
  - After release plus start with key 000..0, round 1 = 62636363626363636263636362636363.
- Back-to-back:
  - Assert start in the done cycle.
  - A new schedule begins the next edge with round_num=0 and Rcon restarting at 01.
- With AES_KEY_EXP_LAST_KEY_EN defined:
  - last_key = d014f9a8c9ee2589e13f0cc8b6630ca6 after the FIPS run.
  - It holds through IDLE.

Source files
------------

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: emits round keys 0..10, one per valid/ready handshake.
// Optional macro AES_KEY_EXP_LAST_KEY_EN adds a last_key output holding the latest round-10 key.
module aes_key_expansion #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_num,
   output logic         key_valid,
   output logic         busy,
   output logic         done
`ifdef AES_KEY_EXP_LAST_KEY_EN
   ,
   output logic [127:0] last_key
`endif
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   // FIPS-197 S-box, byte 0x00 in the most significant position.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   typedef enum logic {IDLE, GEN} state_t;

   state_t        state_q, state_d;
   logic [7:0]    rcon_q, rcon_d, rcon_next;
   logic [127:0]  key_d, next_key;
   logic [3:0]    num_d;
   logic          valid_d, busy_d, done_d;
   logic [31:0]   rot_w3, sub_rot, t, w4, w5, w6, w7;
`ifdef AES_KEY_EXP_LAST_KEY_EN
   logic          last_load;
`endif

   assign rot_w3    = {round_key[23:0], round_key[31:24]};
   assign sub_rot   = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]), sbox(rot_w3[15:8]), sbox(rot_w3[7:0])};
   assign t         = sub_rot ^ {rcon_q, 24'h0};
   assign w4        = round_key[127:96] ^ t;
   assign w5        = w4 ^ round_key[95:64];
   assign w6        = w5 ^ round_key[63:32];
   assign w7        = w6 ^ round_key[31:0];
   assign next_key  = {w4, w5, w6, w7};
   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   always_comb begin
      state_d = state_q;
      key_d   = round_key;
      num_d   = round_num;
      valid_d = key_valid;
      busy_d  = busy;
      done_d  = 1'b0;
      rcon_d  = rcon_q;
`ifdef AES_KEY_EXP_LAST_KEY_EN
      last_load = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key_in;
               num_d   = 4'd0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               rcon_d  = 8'h01;
               state_d = GEN;
            end
         end
         GEN: begin
            if (key_valid && ready) begin
               if (round_num == LAST_ROUND) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  key_d  = next_key;
                  num_d  = round_num + 4'd1;
                  rcon_d = rcon_next;
`ifdef AES_KEY_EXP_LAST_KEY_EN
                  last_load = (round_num == LAST_ROUND - 4'd1);
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         round_key <= '0;
         round_num <= '0;
         key_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rcon_q    <= 8'h01;
      end else begin
         state_q   <= state_d;
         round_key <= key_d;
         round_num <= num_d;
         key_valid <= valid_d;
         busy      <= busy_d;
         done      <= done_d;
         rcon_q    <= rcon_d;
      end
   end

`ifdef AES_KEY_EXP_LAST_KEY_EN
   // Seed for the decryption schedule; survives IDLE until the next round-10 key.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_key <= '0;
      else if (last_load)
         last_key <= next_key;
   end
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion; expected keys come from an independent word-wise
// FIPS-197 expansion with an S-box derived from GF(2^8) inversion, plus published vectors.
module tb_aes_key_expansion;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] FIPS_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         ready = 1'b0;
   logic [127:0] key_in = '0;
   logic [127:0] round_key;
   logic [3:0]   round_num;
   logic         key_valid, busy, done;
`ifdef AES_KEY_EXP_LAST_KEY_EN
   logic [127:0] last_key;
`endif

   typedef struct packed {
      logic [3:0]   num;
      logic [127:0] key;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] sbox_ref[256];
   int         n_compared = 0;
   int         n_mismatched = 0;

   aes_key_expansion #(.NR(10)) dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .ready(ready),
      .round_key(round_key), .round_num(round_num), .key_valid(key_valid),
      .busy(busy), .done(done)
`ifdef AES_KEY_EXP_LAST_KEY_EN
      , .last_key(last_key)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d = {v, v};
      return d[15-n -: 8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int i = 0; i < 256; i++) begin
         inv = 8'h00;
         for (int j = 1; j < 256; j++)
            if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
         sbox_ref[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic push_schedule(input logic [127:0] k);
      logic [31:0] w[44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]}
                  ^ {rc, 24'h0};
            rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= 10; r++)
         sb.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; ready = 1'b0; key_in = '0;
      @(negedge clk); @(negedge clk);
      n_compared++; if (round_key !== 128'h0) begin n_mismatched++; $display("[TB] FAIL reset_key: got %h want 0", round_key); end
      n_compared++; if (round_num !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_num: got %0d want 0", round_num); end
      n_compared++; if (key_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", key_valid); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      rst = 1'b1;
      @(negedge clk);
      n_compared++; if (key_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_valid: got %b want 0", key_valid); end
   endtask

   task automatic test_fips();
      exp_t e;
      push_schedule(FIPS_KEY);
      start = 1'b1; key_in = FIPS_KEY; ready = 1'b1;
      @(negedge clk);
      start = 1'b0; key_in = 128'h0123456789abcdeffedcba9876543210;
      for (int c = 0; c <= 10; c++) begin
         n_compared++; if (key_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fips_valid c%0d: got %b want 1", c, key_valid); end
         n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fips_busy c%0d: got %b want 1", c, busy); end
         n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fips_done_early c%0d: got %b want 0", c, done); end
         n_compared++;
         if (sb.size() == 0) begin n_mismatched++; $display("[TB] FAIL fips_sb_empty c%0d: got empty want entry", c); end
         else begin
            e = sb.pop_front();
            if (round_key !== e.key || round_num !== e.num) begin
               n_mismatched++; $display("[TB] FAIL fips_key c%0d: got %0d/%h want %0d/%h", c, round_num, round_key, e.num, e.key);
            end
         end
         if (c == 1) begin n_compared++; if (round_key !== FIPS_R1) begin n_mismatched++; $display("[TB] FAIL fips_r1: got %h want %h", round_key, FIPS_R1); end end
         if (c == 2) begin n_compared++; if (round_key !== FIPS_R2) begin n_mismatched++; $display("[TB] FAIL fips_r2: got %h want %h", round_key, FIPS_R2); end end
         if (c == 10) begin n_compared++; if (round_key !== FIPS_R10) begin n_mismatched++; $display("[TB] FAIL fips_r10: got %h want %h", round_key, FIPS_R10); end end
         @(negedge clk);
      end
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fips_done: got %b want 1", done); end
      n_compared++; if (key_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fips_end_valid: got %b want 0", key_valid); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fips_end_busy: got %b want 0", busy); end
      n_compared++; if (round_num !== 4'd10) begin n_mismatched++; $display("[TB] FAIL fips_hold_num: got %0d want 10", round_num); end
      @(negedge clk);
      n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fips_done_pulse: got %b want 0", done); end
      n_compared++; if (round_key !== FIPS_R10) begin n_mismatched++; $display("[TB] FAIL fips_hold_key: got %h want %h", round_key, FIPS_R10); end
`ifdef AES_KEY_EXP_LAST_KEY_EN
      n_compared++; if (last_key !== FIPS_R10) begin n_mismatched++; $display("[TB] FAIL last_key: got %h want %h", last_key, FIPS_R10); end
      repeat (3) @(negedge clk);
      n_compared++; if (last_key !== FIPS_R10) begin n_mismatched++; $display("[TB] FAIL last_key_hold: got %h want %h", last_key, FIPS_R10); end
`endif
   endtask

   task automatic test_backpressure();
      exp_t e;
      push_schedule(FIPS_KEY);
      start = 1'b1; key_in = FIPS_KEY; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         if (c == 3) begin
            ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               n_compared++;
               if (round_key !== FIPS_R3 || round_num !== 4'd3 || key_valid !== 1'b1) begin
                  n_mismatched++; $display("[TB] FAIL stall s%0d: got %0d/%b/%h want 3/1/%h", s, round_num, key_valid, round_key, FIPS_R3);
               end
            end
            ready = 1'b1;
         end
         n_compared++;
         if (sb.size() == 0) begin n_mismatched++; $display("[TB] FAIL bp_sb_empty c%0d: got empty want entry", c); end
         else begin
            e = sb.pop_front();
            if (key_valid !== 1'b1 || round_key !== e.key || round_num !== e.num) begin
               n_mismatched++; $display("[TB] FAIL bp_key c%0d: got %b %0d/%h want 1 %0d/%h", c, key_valid, round_num, round_key, e.num, e.key);
            end
         end
         @(negedge clk);
      end
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_done: got %b want 1", done); end
      @(negedge clk);
   endtask

   task automatic test_start_busy();
      exp_t e;
      push_schedule(FIPS_KEY);
      start = 1'b1; key_in = FIPS_KEY; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         start = (c == 5);
         if (c == 5) key_in = '0;
         n_compared++;
         if (sb.size() == 0) begin n_mismatched++; $display("[TB] FAIL sbusy_sb_empty c%0d: got empty want entry", c); end
         else begin
            e = sb.pop_front();
            if (key_valid !== 1'b1 || round_key !== e.key || round_num !== e.num) begin
               n_mismatched++; $display("[TB] FAIL sbusy_key c%0d: got %b %0d/%h want 1 %0d/%h", c, key_valid, round_num, round_key, e.num, e.key);
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sbusy_done: got %b want 1", done); end
      @(negedge clk);
      n_compared++; if (key_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sbusy_no_restart: got %b want 0", key_valid); end
   endtask

   task automatic test_async_reset();
      exp_t e;
      push_schedule(FIPS_KEY);
      start = 1'b1; key_in = FIPS_KEY; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         e = sb.pop_front();
         n_compared++;
         if (key_valid !== 1'b1 || round_key !== e.key) begin
            n_mismatched++; $display("[TB] FAIL ar_key c%0d: got %b %h want 1 %h", c, key_valid, round_key, e.key);
         end
         @(negedge clk);
      end
      sb.delete();
      #2 rst = 1'b0;
      #1;
      n_compared++;
      if (round_key !== 128'h0 || round_num !== 4'd0 || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_mismatched++; $display("[TB] FAIL async_reset: got %h %0d %b %b %b want all 0", round_key, round_num, key_valid, busy, done);
      end
      @(negedge clk);
      rst = 1'b1;
`ifdef AES_KEY_EXP_LAST_KEY_EN
      n_compared++; if (last_key !== 128'h0) begin n_mismatched++; $display("[TB] FAIL last_key_reset: got %h want 0", last_key); end
`endif
      push_schedule(128'h0);
      start = 1'b1; key_in = '0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         n_compared++;
         if (sb.size() == 0) begin n_mismatched++; $display("[TB] FAIL zero_sb_empty c%0d: got empty want entry", c); end
         else begin
            e = sb.pop_front();
            if (key_valid !== 1'b1 || round_key !== e.key || round_num !== e.num) begin
               n_mismatched++; $display("[TB] FAIL zero_key c%0d: got %b %0d/%h want 1 %0d/%h", c, key_valid, round_num, round_key, e.num, e.key);
            end
         end
         if (c == 1) begin n_compared++; if (round_key !== ZERO_R1) begin n_mismatched++; $display("[TB] FAIL zero_r1: got %h want %h", round_key, ZERO_R1); end end
         @(negedge clk);
      end
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_done: got %b want 1", done); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      push_schedule(FIPS_KEY);
      push_schedule(128'h0);
      start = 1'b1; key_in = FIPS_KEY; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 22; c++) begin
         if (c == 11) begin
            n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_done: got %b want 1", done); end
            start = 1'b1; key_in = '0;
            @(negedge clk);
            start = 1'b0;
            n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_done_clear: got %b want 0", done); end
         end
         n_compared++;
         if (sb.size() == 0) begin n_mismatched++; $display("[TB] FAIL b2b_sb_empty c%0d: got empty want entry", c); end
         else begin
            e = sb.pop_front();
            if (key_valid !== 1'b1 || round_key !== e.key || round_num !== e.num) begin
               n_mismatched++; $display("[TB] FAIL b2b_key c%0d: got %b %0d/%h want 1 %0d/%h", c, key_valid, round_num, round_key, e.num, e.key);
            end
         end
         @(negedge clk);
      end
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_done2: got %b want 1", done); end
      @(negedge clk);
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips();
      test_backpressure();
      test_start_busy();
      test_async_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
